// File: rtl/msi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : msi_pkg
//  Description : Bus message encodings shared between the MSI caches and the
//                bus controller, plus the bus controller FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package msi_pkg;

    // Bus message encoding (shared with the cache controllers)
    localparam int          c_msg_w      = 3;
    localparam logic [2:0]  c_msg_idle   = 3'd0;
    localparam logic [2:0]  c_msg_rd     = 3'd1;
    localparam logic [2:0]  c_msg_rdx    = 3'd2;
    localparam logic [2:0]  c_msg_upgr   = 3'd3;
    localparam logic [2:0]  c_msg_flush  = 3'd4;

    // Bus controller FSM state encoding
    localparam int          c_st_w       = 3;
    localparam logic [2:0]  c_st_idle    = 3'd0;
    localparam logic [2:0]  c_st_grant   = 3'd1;
    localparam logic [2:0]  c_st_snoop   = 3'd2;
    localparam logic [2:0]  c_st_flush   = 3'd3;
    localparam logic [2:0]  c_st_mem     = 3'd4;
    localparam logic [2:0]  c_st_done    = 3'd5;

    // A cache may only originate RD, RDX or UPGR on the bus
    function automatic logic msg_is_request(input logic [2:0] msg);
        return (msg == c_msg_rd) || (msg == c_msg_rdx) || (msg == c_msg_upgr);
    endfunction

    // Messages that return a line of data to the requester
    function automatic logic msg_has_data(input logic [2:0] msg);
        return (msg == c_msg_rd) || (msg == c_msg_rdx);
    endfunction

endpackage : msi_pkg
`default_nettype wire

// File: rtl/msi_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : msi_rr_arbiter
//  Description : Combinational round-robin arbiter. Searches the request
//                vector starting at rr_ptr_i and returns the first requester
//                as a one-hot grant plus its index.
//  Revision    : 1.0  initial release
// ============================================================================
module msi_rr_arbiter #(
    parameter int NUM_CPUS = 2,
    parameter int IDX_W    = 1
) (
    input  logic [NUM_CPUS-1:0] req_i,
    input  logic [IDX_W-1:0]    rr_ptr_i,
    output logic [NUM_CPUS-1:0] grant_o,
    output logic [IDX_W-1:0]    grant_idx_o
);

    localparam logic [IDX_W:0] c_num = (IDX_W+1)'(NUM_CPUS);

    logic [2*NUM_CPUS-1:0] w_req_dbl;
    logic [NUM_CPUS-1:0]   w_req_rot;
    logic                  w_found;

    // Rotating a doubled copy puts the highest-priority requester at bit 0
    assign w_req_dbl = {req_i, req_i};
    assign w_req_rot = NUM_CPUS'(w_req_dbl >> rr_ptr_i);

    // First set bit in the rotated vector, mapped back to an absolute index
    always_comb begin
        logic [IDX_W:0] sum;
        w_found     = 1'b0;
        sum         = '0;
        grant_idx_o = '0;
        for (int i = 0; i < NUM_CPUS; i++) begin
            if (!w_found && w_req_rot[i]) begin
                w_found = 1'b1;
                sum     = {1'b0, rr_ptr_i} + (IDX_W+1)'(i);
            end
        end
        if (sum >= c_num) begin
            sum = sum - c_num;
        end
        grant_idx_o = sum[IDX_W-1:0];
    end

    // One-hot grant only when someone actually requested
    assign grant_o = w_found ? (NUM_CPUS'(1) << grant_idx_o) : '0;

endmodule : msi_rr_arbiter
`default_nettype wire

// File: rtl/msi_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : msi_bus_ctrl
//  Description : Shared-bus controller for MSI snooping caches. Arbitrates
//                one transaction at a time, broadcasts it, checks the flush
//                responses and models memory latency before acknowledging.
//  Revision    : 1.0  initial release
// ============================================================================
module msi_bus_ctrl
    import msi_pkg::*;
#(
    parameter int NUM_CPUS = 2,
    parameter int ADDR_W   = 1,
    parameter int MEM_LAT  = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [NUM_CPUS-1:0]          pr_bus_req_i,
    input  logic [3*NUM_CPUS-1:0]        pr_msg_i,
    input  logic [ADDR_W*NUM_CPUS-1:0]   pr_addr_i,
    output logic [NUM_CPUS-1:0]          grant_o,
    output logic [2:0]                   bus_msg_o,
    output logic [ADDR_W-1:0]            bus_addr_o,
    output logic [$clog2(NUM_CPUS)-1:0]  bus_src_o,
    input  logic [NUM_CPUS-1:0]          flush_i,
    output logic                         data_valid_o,
    output logic [NUM_CPUS-1:0]          ack_o,
    output logic                         busy_o,
    output logic                         err_o
);

    localparam int c_idx_w = $clog2(NUM_CPUS);
    localparam int c_cnt_w = $clog2(MEM_LAT+1);
    localparam int c_pop_w = $clog2(NUM_CPUS+1);

    localparam logic [c_idx_w-1:0] c_last_cpu = c_idx_w'(NUM_CPUS-1);
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'(MEM_LAT-1);
    localparam logic [c_pop_w-1:0] c_one      = c_pop_w'(1);

    logic [c_st_w-1:0]    r_state;
    logic [c_st_w-1:0]    w_next_state;
    logic [c_idx_w-1:0]   r_win;
    logic [NUM_CPUS-1:0]  r_win_oh;
    logic [2:0]           r_msg;
    logic [ADDR_W-1:0]    r_addr;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [c_idx_w-1:0]   r_rr_ptr;

    logic [NUM_CPUS-1:0]  w_arb_grant;
    logic [c_idx_w-1:0]   w_arb_idx;
    logic [2:0]           w_win_msg;
    logic [ADDR_W-1:0]    w_win_addr;
    logic [NUM_CPUS-1:0]  w_flush_masked;
    logic [c_pop_w-1:0]   w_flush_cnt;
    logic                 w_any_req;

    assign w_any_req = |pr_bus_req_i;

    msi_rr_arbiter #(
        .NUM_CPUS (NUM_CPUS),
        .IDX_W    (c_idx_w)
    ) u_arb (
        .req_i       (pr_bus_req_i),
        .rr_ptr_i    (r_rr_ptr),
        .grant_o     (w_arb_grant),
        .grant_idx_o (w_arb_idx)
    );

    // Select the latched winner's message and address slices
    always_comb begin
        w_win_msg  = c_msg_idle;
        w_win_addr = '0;
        for (int k = 0; k < NUM_CPUS; k++) begin
            if (r_win == c_idx_w'(k)) begin
                w_win_msg  = pr_msg_i[3*k +: 3];
                w_win_addr = pr_addr_i[ADDR_W*k +: ADDR_W];
            end
        end
    end

    // Count flush responders, ignoring the issuing cache's own bit
    assign w_flush_masked = flush_i & ~r_win_oh;

    always_comb begin
        w_flush_cnt = '0;
        for (int k = 0; k < NUM_CPUS; k++) begin
            w_flush_cnt = w_flush_cnt + c_pop_w'(w_flush_masked[k]);
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_st_idle:  if (w_any_req) w_next_state = c_st_grant;
            c_st_grant: w_next_state = msg_is_request(w_win_msg) ? c_st_snoop : c_st_idle;
            c_st_snoop: begin
                if (r_msg == c_msg_upgr)        w_next_state = c_st_done;
                else if (w_flush_cnt != '0)     w_next_state = c_st_flush;
                else                            w_next_state = c_st_mem;
            end
            c_st_flush: w_next_state = c_st_done;
            c_st_mem:   if (r_cnt == '0) w_next_state = c_st_done;
            c_st_done:  w_next_state = c_st_idle;
            default:    w_next_state = c_st_idle;
        endcase
    end

    // Winner, transaction, latency counter and round-robin pointer registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_win    <= '0;
            r_win_oh <= '0;
            r_msg    <= c_msg_idle;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_any_req) begin
                        r_win    <= w_arb_idx;
                        r_win_oh <= w_arb_grant;
                    end
                end
                c_st_grant: begin
                    r_msg  <= w_win_msg;
                    r_addr <= w_win_addr;
                end
                c_st_snoop: r_cnt <= c_cnt_load;
                c_st_mem:   if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
                c_st_done:  r_rr_ptr <= (r_win == c_last_cpu) ? '0 : r_win + 1'b1;
                default:    ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        grant_o      = '0;
        bus_msg_o    = c_msg_idle;
        bus_addr_o   = '0;
        bus_src_o    = '0;
        data_valid_o = 1'b0;
        ack_o        = '0;
        err_o        = 1'b0;
        busy_o       = (r_state != c_st_idle);
        case (r_state)
            c_st_grant: begin
                grant_o = r_win_oh;
                err_o   = !msg_is_request(w_win_msg);
            end
            c_st_snoop: begin
                bus_msg_o  = r_msg;
                bus_addr_o = r_addr;
                bus_src_o  = r_win;
                err_o      = msg_has_data(r_msg) && (w_flush_cnt > c_one);
            end
            c_st_flush: begin
                bus_msg_o  = c_msg_flush;
                bus_addr_o = r_addr;
            end
            c_st_mem: begin
                bus_addr_o = r_addr;
            end
            c_st_done: begin
                bus_addr_o   = r_addr;
                ack_o        = r_win_oh;
                data_valid_o = msg_has_data(r_msg);
            end
            default: ;
        endcase
    end

endmodule : msi_bus_ctrl
`default_nettype wire

// File: tb/tb_msi_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_msi_bus_ctrl
//  Description : Self-checking bench for msi_bus_ctrl with three caches.
//                Directed scenarios followed by random transactions, each
//                checked cycle by cycle against a transaction-level model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_msi_bus_ctrl;

    localparam int N   = 3;
    localparam int AW  = 2;
    localparam int LAT = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [N-1:0]  pr_bus_req_i;
    logic [3*N-1:0]  pr_msg_i;
    logic [AW*N-1:0] pr_addr_i;
    logic [N-1:0]  grant_o;
    logic [2:0]    bus_msg_o;
    logic [AW-1:0] bus_addr_o;
    logic [1:0]    bus_src_o;
    logic [N-1:0]  flush_i;
    logic          data_valid_o;
    logic [N-1:0]  ack_o;
    logic          busy_o;
    logic          err_o;

    int n_tests  = 0;
    int n_fail   = 0;
    int model_rr = 0;

    msi_bus_ctrl #(.NUM_CPUS(N), .ADDR_W(AW), .MEM_LAT(LAT)) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .pr_bus_req_i (pr_bus_req_i),
        .pr_msg_i     (pr_msg_i),
        .pr_addr_i    (pr_addr_i),
        .grant_o      (grant_o),
        .bus_msg_o    (bus_msg_o),
        .bus_addr_o   (bus_addr_o),
        .bus_src_o    (bus_src_o),
        .flush_i      (flush_i),
        .data_valid_o (data_valid_o),
        .ack_o        (ack_o),
        .busy_o       (busy_o),
        .err_o        (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare every output at the falling edge of the current cycle
    task automatic chk_all(input string tag, input int g, input int m, input int a,
                           input int s, input int dv, input int ak, input int bz, input int er);
        @(negedge clk_i);
        chk({tag, "/grant"}, 32'(grant_o),      32'(g));
        chk({tag, "/msg"},   32'(bus_msg_o),    32'(m));
        chk({tag, "/addr"},  32'(bus_addr_o),   32'(a));
        chk({tag, "/src"},   32'(bus_src_o),    32'(s));
        chk({tag, "/dv"},    32'(data_valid_o), 32'(dv));
        chk({tag, "/ack"},   32'(ack_o),        32'(ak));
        chk({tag, "/busy"},  32'(busy_o),       32'(bz));
        chk({tag, "/err"},   32'(err_o),        32'(er));
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Round-robin choice: first requester at or after the pointer, wrapping
    function automatic int pick(input logic [N-1:0] req, input int rr);
        for (int k = 0; k < N; k++) begin
            if (req[(rr + k) % N]) return (rr + k) % N;
        end
        return 0;
    endfunction

    function automatic logic [3*N-1:0] pk_msg(input int m0, input int m1, input int m2);
        return {3'(m2), 3'(m1), 3'(m0)};
    endfunction

    function automatic logic [AW*N-1:0] pk_addr(input int a0, input int a1, input int a2);
        return {2'(a2), 2'(a1), 2'(a0)};
    endfunction

    // One complete bus transaction; starts and ends in an idle cycle just after a rising edge.
    // abort_at = k (1..LAT) asserts reset during the k-th memory-wait cycle.
    task automatic txn(input string name, input logic [N-1:0] req, input logic [3*N-1:0] msgs,
                       input logic [AW*N-1:0] addrs, input logic [N-1:0] snoop_flush,
                       input bit drop_early, input int abort_at);
        int win, msg, addr, nfl, oh;
        bit bad, data;
        logic [3*N-1:0] mv;
        logic [AW*N-1:0] av;
        mv   = msgs;
        av   = addrs;
        win  = pick(req, model_rr);
        oh   = 1 << win;
        msg  = int'(mv[3*win +: 3]);
        addr = int'(av[AW*win +: AW]);
        bad  = !(msg == 1 || msg == 2 || msg == 3);
        data = (msg == 1 || msg == 2);

        // arbitration cycle
        pr_bus_req_i = req;
        pr_msg_i     = msgs;
        pr_addr_i    = addrs;
        flush_i      = N'($urandom);
        chk_all({name, "/c0"}, 0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // grant cycle
        if (drop_early) pr_bus_req_i = '0;
        flush_i = N'($urandom);
        chk_all({name, "/grant"}, oh, 0, 0, 0, 0, 0, 1, int'(bad));
        step();
        pr_bus_req_i = drop_early ? '0 : (req & ~N'(oh));
        pr_msg_i     = (3*N)'($urandom);
        pr_addr_i    = (AW*N)'($urandom);

        if (!bad) begin
            // snoop cycle
            flush_i = snoop_flush;
            nfl     = $countones(snoop_flush & ~N'(oh));
            chk_all({name, "/snoop"}, 0, msg, addr, win, 0, 0, 1, int'(data && nfl > 1));
            step();
            flush_i = N'($urandom);
            if (msg != 3) begin
                if (nfl > 0) begin
                    chk_all({name, "/flush"}, 0, 4, addr, 0, 0, 0, 1, 0);
                    step();
                    flush_i = N'($urandom);
                end else begin
                    for (int k = 1; k <= LAT; k++) begin
                        if (abort_at == k) rst_i = 1'b1;
                        chk_all({name, "/mem"}, 0, 0, addr, 0, 0, 0, 1, 0);
                        step();
                        if (abort_at == k) begin
                            rst_i        = 1'b0;
                            pr_bus_req_i = '0;
                            model_rr     = 0;
                            chk_all({name, "/after_rst"}, 0, 0, 0, 0, 0, 0, 0, 0);
                            step();
                            return;
                        end
                        flush_i = N'($urandom);
                    end
                end
            end
            // completion cycle
            chk_all({name, "/done"}, 0, 0, addr, 0, int'(data), oh, 1, 0);
            model_rr = (win + 1) % N;
            step();
        end

        // trailing idle cycle with no requests
        pr_bus_req_i = '0;
        chk_all({name, "/idle"}, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
    endtask

    initial begin
        int m0, m1, m2;
        logic [N-1:0] fl;
        int mtab [10] = '{1, 1, 2, 2, 3, 3, 1, 2, 0, 4};

        rst_i        = 1'b1;
        pr_bus_req_i = '0;
        pr_msg_i     = '0;
        pr_addr_i    = '0;
        flush_i      = '0;
        step();
        step();
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        rst_i = 1'b0;
        step();

        // Directed scenarios
        txn("t1_rd_mem",     3'b001, pk_msg(1, 0, 0), pk_addr(1, 0, 0), 3'b000, 0, 0);
        txn("t2_rdx_flush",  3'b010, pk_msg(0, 2, 0), pk_addr(0, 0, 0), 3'b001, 0, 0);
        txn("t3_upgr",       3'b001, pk_msg(3, 0, 0), pk_addr(1, 0, 0), 3'b110, 0, 0);
        txn("t6_rst_abort",  3'b100, pk_msg(0, 0, 1), pk_addr(0, 0, 3), 3'b000, 0, 2);
        txn("t6_after",      3'b010, pk_msg(0, 1, 0), pk_addr(0, 2, 0), 3'b000, 0, 0);
        txn("t4_both_a",     3'b011, pk_msg(1, 2, 0), pk_addr(2, 3, 0), 3'b000, 0, 0);
        txn("t4_both_b",     3'b011, pk_msg(1, 2, 0), pk_addr(2, 3, 0), 3'b000, 0, 0);
        txn("t5_msg_flush",  3'b001, pk_msg(4, 0, 0), pk_addr(1, 0, 0), 3'b000, 0, 0);
        txn("t5_msg_idle",   3'b001, pk_msg(0, 0, 0), pk_addr(1, 0, 0), 3'b000, 0, 0);
        txn("t5_multi_fl",   3'b001, pk_msg(1, 0, 0), pk_addr(3, 0, 0), 3'b111, 0, 0);
        txn("own_flush",     3'b001, pk_msg(2, 0, 0), pk_addr(2, 0, 0), 3'b001, 0, 0);
        txn("drop_early",    3'b100, pk_msg(0, 0, 1), pk_addr(0, 0, 1), 3'b000, 1, 0);
        txn("wrap_rr",       3'b111, pk_msg(1, 1, 1), pk_addr(1, 2, 3), 3'b000, 0, 0);

        // Random transactions
        for (int t = 0; t < 80; t++) begin
            m0 = mtab[$urandom_range(0, 9)];
            m1 = mtab[$urandom_range(0, 9)];
            m2 = mtab[$urandom_range(0, 9)];
            fl = ($urandom_range(0, 9) < 4) ? 3'b000 : N'($urandom);
            txn($sformatf("rnd%0d", t), N'($urandom_range(1, 7)), pk_msg(m0, m1, m2),
                (AW*N)'($urandom), fl, ($urandom_range(0, 5) == 0),
                ($urandom_range(0, 14) == 0) ? int'($urandom_range(1, LAT)) : 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_msi_bus_ctrl
`default_nettype wire
